// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multicycle CPU control path: state codes, opcodes,
// ALUOp and mux-select constants, and the registered control-word layout.
package cpu_defs;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEM_ADDR = 4'd3,
        S_MEM_READ = 4'd4,
        S_MEM_WB   = 4'd5,
        S_MEM_WRITE= 4'd6,
        S_R_EXEC   = 4'd7,
        S_R_WB     = 4'd8,
        S_BRANCH   = 4'd9,
        S_JUMP     = 4'd10,
        S_IMM_EXEC = 4'd11,
        S_IMM_WB   = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;

    localparam logic [1:0] ALUOP_FUNCT = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_ADD   = 2'b10;
    localparam logic [1:0] ALUOP_IMM   = 2'b11;

    localparam logic       ALU_A_PC      = 1'b0;
    localparam logic       ALU_A_REG     = 1'b1;
    localparam logic [1:0] ALU_B_REG     = 2'b00;
    localparam logic [1:0] ALU_B_FOUR    = 2'b01;
    localparam logic [1:0] ALU_B_IMM     = 2'b10;
    localparam logic [1:0] ALU_B_IMM_SH2 = 2'b11;

    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    // Moore part of the control word; ir_write and the FETCH pc_write are gated separately.
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       branch_ne;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
    } ctrl_t;

    function automatic logic is_legal_op(input logic [5:0] op);
        case (op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J,
            OP_ADDI, OP_ORI, OP_LUI: return 1'b1;
            default:                 return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle control FSM (master) and the datapath (slave).
interface multicycle_control_if #(
    parameter int CNT_W = 32
);
    logic [5:0]       opcode;
    logic             mem_ready;
    logic             pc_write;
    logic             pc_write_cond;
    logic             branch_ne;
    logic             i_or_d;
    logic             mem_read;
    logic             mem_write;
    logic             ir_write;
    logic             mem_to_reg;
    logic             reg_dst;
    logic             reg_write;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [1:0]       alu_op;
    logic [1:0]       pc_source;
    logic             illegal_op;
    logic [CNT_W-1:0] retired;
    logic [3:0]       state;

    modport master (
        input  opcode, mem_ready,
        output pc_write, pc_write_cond, branch_ne, i_or_d, mem_read, mem_write,
               ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b,
               alu_op, pc_source, illegal_op, retired, state
    );

    modport slave (
        output opcode, mem_ready,
        input  pc_write, pc_write_cond, branch_ne, i_or_d, mem_read, mem_write,
               ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b,
               alu_op, pc_source, illegal_op, retired, state
    );
endinterface

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS-subset CPU; 3-5 cycles per instruction,
// stalls in FETCH/MEM_READ/MEM_WRITE while mem_ready is low, counts retired instructions.
module multicycle_control
    import cpu_defs::*;
#(
    parameter int CNT_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    multicycle_control_if.master bus
);

    state_t           state_q, state_d;
    ctrl_t            ctrl_q, ctrl_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             retire;
    logic             fetch_fire;

    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        case (state_q)
            S_IDLE:      state_d = S_FETCH;
            S_FETCH:     if (bus.mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (bus.opcode)
                    OP_LW, OP_SW:            state_d = S_MEM_ADDR;
                    OP_RTYPE:                state_d = S_R_EXEC;
                    OP_BEQ, OP_BNE:          state_d = S_BRANCH;
                    OP_J:                    state_d = S_JUMP;
                    OP_ADDI, OP_ORI, OP_LUI: state_d = S_IMM_EXEC;
                    default:                 state_d = S_FETCH;
                endcase
            end
            S_MEM_ADDR:  state_d = (bus.opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ:  if (bus.mem_ready) state_d = S_MEM_WB;
            S_MEM_WB: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_MEM_WRITE: begin
                if (bus.mem_ready) begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end
            end
            S_R_EXEC:    state_d = S_R_WB;
            S_IMM_EXEC:  state_d = S_IMM_WB;
            S_R_WB, S_BRANCH, S_JUMP, S_IMM_WB: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            default:     state_d = S_FETCH;
        endcase
        retired_d = retire ? retired_q + CNT_W'(1) : retired_q;
    end

    // Control word is decoded from the next state so the outputs come straight off flops.
    // opcode is only consulted for BRANCH, which is always entered from DECODE where it is stable.
    always_comb begin
        ctrl_d = '0;
        case (state_d)
            S_FETCH: begin
                ctrl_d.mem_read  = 1'b1;
                ctrl_d.alu_src_a = ALU_A_PC;
                ctrl_d.alu_src_b = ALU_B_FOUR;
                ctrl_d.alu_op    = ALUOP_ADD;
                ctrl_d.pc_source = PC_SRC_ALU;
            end
            S_DECODE: begin
                ctrl_d.alu_src_a = ALU_A_PC;
                ctrl_d.alu_src_b = ALU_B_IMM_SH2;
                ctrl_d.alu_op    = ALUOP_ADD;
            end
            S_MEM_ADDR: begin
                ctrl_d.alu_src_a = ALU_A_REG;
                ctrl_d.alu_src_b = ALU_B_IMM;
                ctrl_d.alu_op    = ALUOP_ADD;
            end
            S_MEM_READ: begin
                ctrl_d.mem_read = 1'b1;
                ctrl_d.i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                ctrl_d.reg_write  = 1'b1;
                ctrl_d.mem_to_reg = 1'b1;
            end
            S_MEM_WRITE: begin
                ctrl_d.mem_write = 1'b1;
                ctrl_d.i_or_d    = 1'b1;
            end
            S_R_EXEC: begin
                ctrl_d.alu_src_a = ALU_A_REG;
                ctrl_d.alu_src_b = ALU_B_REG;
                ctrl_d.alu_op    = ALUOP_FUNCT;
            end
            S_R_WB: begin
                ctrl_d.reg_write = 1'b1;
                ctrl_d.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                ctrl_d.alu_src_a     = ALU_A_REG;
                ctrl_d.alu_src_b     = ALU_B_REG;
                ctrl_d.pc_write_cond = 1'b1;
                ctrl_d.pc_source     = PC_SRC_ALUOUT;
                ctrl_d.branch_ne     = bus.opcode[0];
                // bne goes through the ALU decoder, which maps opcode 0x05 to subtract
                ctrl_d.alu_op        = bus.opcode[0] ? ALUOP_IMM : ALUOP_SUB;
            end
            S_JUMP: begin
                ctrl_d.pc_write  = 1'b1;
                ctrl_d.pc_source = PC_SRC_JUMP;
            end
            S_IMM_EXEC: begin
                ctrl_d.alu_src_a = ALU_A_REG;
                ctrl_d.alu_src_b = ALU_B_IMM;
                ctrl_d.alu_op    = ALUOP_IMM;
            end
            S_IMM_WB: begin
                ctrl_d.reg_write = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            ctrl_q    <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            ctrl_q    <= ctrl_d;
            retired_q <= retired_d;
        end
    end

    assign fetch_fire = (state_q == S_FETCH) && bus.mem_ready;

    assign bus.pc_write      = ctrl_q.pc_write | fetch_fire;
    assign bus.ir_write      = fetch_fire;
    assign bus.pc_write_cond = ctrl_q.pc_write_cond;
    assign bus.branch_ne     = ctrl_q.branch_ne;
    assign bus.i_or_d        = ctrl_q.i_or_d;
    assign bus.mem_read      = ctrl_q.mem_read;
    assign bus.mem_write     = ctrl_q.mem_write;
    assign bus.mem_to_reg    = ctrl_q.mem_to_reg;
    assign bus.reg_dst       = ctrl_q.reg_dst;
    assign bus.reg_write     = ctrl_q.reg_write;
    assign bus.alu_src_a     = ctrl_q.alu_src_a;
    assign bus.alu_src_b     = ctrl_q.alu_src_b;
    assign bus.alu_op        = ctrl_q.alu_op;
    assign bus.pc_source     = ctrl_q.pc_source;
    assign bus.illegal_op    = (state_q == S_DECODE) && !is_legal_op(bus.opcode);
    assign bus.retired       = retired_q;
    assign bus.state         = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench for multicycle_control: per-instruction expected state trace and
// per-state output table, plus directed reset, wait-state and illegal-opcode cases.
module tb_multicycle_control;
    import cpu_defs::*;

    localparam int CNT_W = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   model_retired = 0;

    multicycle_control_if #(.CNT_W(CNT_W)) bus ();

    multicycle_control #(.CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [17:0] obs_vec;
    assign obs_vec = {bus.pc_write, bus.pc_write_cond, bus.branch_ne, bus.i_or_d,
                      bus.mem_read, bus.mem_write, bus.ir_write, bus.mem_to_reg,
                      bus.reg_dst, bus.reg_write, bus.alu_src_a, bus.alu_src_b,
                      bus.alu_op, bus.pc_source, bus.illegal_op};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic legal(input logic [5:0] op);
        return op == 6'h00 || op == 6'h23 || op == 6'h2B || op == 6'h04 || op == 6'h05 ||
               op == 6'h02 || op == 6'h08 || op == 6'h0D || op == 6'h0F;
    endfunction

    // Output table straight from the state descriptions; same bit order as obs_vec.
    function automatic logic [17:0] exp_outs(input int st, input logic [5:0] op, input logic mr);
        logic pw = 0, pwc = 0, bne = 0, iod = 0, mrd = 0, mwr = 0, irw = 0;
        logic m2r = 0, rdst = 0, rw = 0, asa = 0, ill = 0;
        logic [1:0] asb = 0, aop = 0, psrc = 0;
        case (st)
            1:  begin mrd = 1; asb = 2'b01; aop = 2'b10; pw = mr; irw = mr; end
            2:  begin asb = 2'b11; aop = 2'b10; ill = !legal(op); end
            3:  begin asa = 1; asb = 2'b10; aop = 2'b10; end
            4:  begin mrd = 1; iod = 1; end
            5:  begin rw = 1; m2r = 1; end
            6:  begin mwr = 1; iod = 1; end
            7:  begin asa = 1; end
            8:  begin rw = 1; rdst = 1; end
            9:  begin asa = 1; pwc = 1; psrc = 2'b01; bne = op[0];
                      aop = (op == 6'h05) ? 2'b11 : 2'b01; end
            10: begin pw = 1; psrc = 2'b10; end
            11: begin asa = 1; asb = 2'b10; aop = 2'b11; end
            12: begin rw = 1; end
            default: ;
        endcase
        return {pw, pwc, bne, iod, mrd, mwr, irw, m2r, rdst, rw, asa, asb, aop, psrc, ill};
    endfunction

    // Runs one instruction starting in its first FETCH cycle (TB sits just after a negedge).
    // fw/mw = wait cycles in FETCH and in the memory-access state.
    task automatic run_instr(input logic [5:0] op, input int fw, input int mw);
        int seq[$];
        int mrq[$];
        logic mr;
        repeat (fw) begin seq.push_back(1); mrq.push_back(0); end
        seq.push_back(1); mrq.push_back(1);
        seq.push_back(2); mrq.push_back(-1);
        case (op)
            6'h00: begin seq.push_back(7); seq.push_back(8); mrq.push_back(-1); mrq.push_back(-1); end
            6'h08, 6'h0D, 6'h0F: begin
                seq.push_back(11); seq.push_back(12); mrq.push_back(-1); mrq.push_back(-1); end
            6'h23: begin
                seq.push_back(3); mrq.push_back(-1);
                repeat (mw) begin seq.push_back(4); mrq.push_back(0); end
                seq.push_back(4); mrq.push_back(1);
                seq.push_back(5); mrq.push_back(-1);
            end
            6'h2B: begin
                seq.push_back(3); mrq.push_back(-1);
                repeat (mw) begin seq.push_back(6); mrq.push_back(0); end
                seq.push_back(6); mrq.push_back(1);
            end
            6'h04, 6'h05: begin seq.push_back(9); mrq.push_back(-1); end
            6'h02: begin seq.push_back(10); mrq.push_back(-1); end
            default: ;
        endcase
        for (int i = 0; i < seq.size(); i++) begin
            bus.opcode = (seq[i] == 1) ? 6'($urandom) : op;
            mr = (mrq[i] < 0) ? 1'($urandom) : 1'(mrq[i]);
            bus.mem_ready = mr;
            #1;
            if (i == 0) check($sformatf("retired op%02h", op), 32'(bus.retired), 32'(model_retired));
            check($sformatf("state op%02h cyc%0d", op, i), 32'(bus.state), 32'(seq[i]));
            check($sformatf("outs op%02h st%0d", op, seq[i]), 32'(obs_vec),
                  32'(exp_outs(seq[i], op, mr)));
            @(posedge clk);
            @(negedge clk);
        end
        if (legal(op)) model_retired = (model_retired + 1) % (1 << CNT_W);
    endtask

    task automatic reset_release();
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.mem_ready = 1'b0;
        #1;
        check("post_reset_state", 32'(bus.state), 32'd1);
        check("post_reset_mem_read", 32'(bus.mem_read), 32'd1);
        check("post_reset_retired", 32'(bus.retired), 32'd0);
    endtask

    logic [5:0] ops [9] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h08, 6'h0D, 6'h0F};

    initial begin
        bus.opcode    = 6'h00;
        bus.mem_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_state", 32'(bus.state), 32'd0);
        check("reset_outs", 32'(obs_vec), 32'd0);
        check("reset_retired", 32'(bus.retired), 32'd0);
        reset_release();

        run_instr(6'h00, 0, 0);
        run_instr(6'h23, 0, 2);
        run_instr(6'h05, 1, 0);
        run_instr(6'h04, 0, 0);
        run_instr(6'h3F, 0, 0);
        run_instr(6'h0D, 0, 0);
        run_instr(6'h2B, 2, 1);
        run_instr(6'h02, 0, 0);

        for (int n = 0; n < 40; n++) begin
            logic [5:0] op;
            op = ($urandom_range(0, 9) < 8) ? ops[$urandom_range(0, 8)] : 6'($urandom);
            run_instr(op, $urandom_range(0, 2), $urandom_range(0, 2));
        end
        check("retired_final", 32'(bus.retired), 32'(model_retired));

        // sw stalled in MEM_WRITE, then reset mid-access
        begin
            int sw_seq[4] = '{1, 2, 3, 6};
            for (int i = 0; i < 4; i++) begin
                bus.opcode = 6'h2B;
                bus.mem_ready = (i == 0);
                #1;
                check($sformatf("sw_abort state cyc%0d", i), 32'(bus.state), 32'(sw_seq[i]));
                if (i < 3) begin
                    @(posedge clk);
                    @(negedge clk);
                end
            end
            check("sw_abort mem_write_before", 32'(bus.mem_write), 32'd1);
            rst = 1'b1;
            #1;
            check("sw_abort mem_write_after", 32'(bus.mem_write), 32'd0);
            check("sw_abort state", 32'(bus.state), 32'd0);
            check("sw_abort outs", 32'(obs_vec), 32'd0);
            check("sw_abort retired", 32'(bus.retired), 32'd0);
            model_retired = 0;
            @(posedge clk);
            @(negedge clk);
            reset_release();
            run_instr(6'h00, 0, 0);
            check("retired_after_abort", 32'(bus.retired), 32'(model_retired));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
